// File: rtl/sqrt_fp16_pkg.sv
// Shared FP16 constants, unpacked-field record and unpack FSM states for the
// square-root pipeline.
package sqrt_fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int MANT_W   = 11;
  localparam int UEXP_W   = 7;
  localparam int EXP_BIAS = 15;

  localparam logic signed [UEXP_W-1:0] EXP_SPECIAL = 7'sd16;
  localparam logic signed [UEXP_W-1:0] EXP_ZERO    = -7'sd15;
  // Subnormals start at the minimum normal exponent before normalisation.
  localparam logic signed [UEXP_W-1:0] EXP_SUB     = -7'sd14;
  localparam logic [EXP_W-1:0]         EXP_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    HOLD
  } state_t;

  typedef struct packed {
    logic                     sign;
    logic signed [UEXP_W-1:0] exp;
    logic [MANT_W-1:0]        mant;
    logic                     is_num;
    logic                     is_nan;
    logic                     is_pinf;
    logic                     is_ninf;
    logic                     need_norm;
  } fp16_fields_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 field split and class decode.
// UNPACK_FTZ_EN: subnormal inputs decode as signed zero and never request normalisation.
module fp16_classify
  import sqrt_fp16_pkg::*;
(
  input  logic [15:0]  data,
  output fp16_fields_t fields
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  assign e = data[14:10];
  assign f = data[FRAC_W-1:0];

  always_comb begin
    fields      = '0;
    fields.sign = data[15];
    if (e == EXP_MAX) begin
      fields.exp = EXP_SPECIAL;
      if (f == '0) begin
        fields.is_pinf = ~data[15];
        fields.is_ninf = data[15];
      end else begin
        fields.is_nan = 1'b1;
        fields.mant   = {1'b1, f};
      end
    end else if (e == '0) begin
      fields.is_num = 1'b1;
      if (f == '0) begin
        fields.exp = EXP_ZERO;
      end else begin
`ifdef UNPACK_FTZ_EN
        fields.exp = EXP_ZERO;
`else
        fields.exp       = EXP_SUB;
        fields.mant      = {1'b0, f};
        fields.need_norm = 1'b1;
`endif
      end
    end else begin
      fields.is_num = 1'b1;
      fields.exp    = $signed({2'b00, e}) - 7'(EXP_BIAS);
      fields.mant   = {1'b1, f};
    end
  end

endmodule

// File: rtl/unpack_fp16.sv
// FP16 unpack front end: classify, normalise subnormals one bit per cycle,
// hold the result under valid/ready. UNPACK_FTZ_EN (in fp16_classify) flushes subnormals.
module unpack_fp16
  import sqrt_fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              out_ready,
  output logic              n_valid,
  output logic              sign,
  output logic signed [6:0] exp,
  output logic [10:0]       mant,
  output logic              is_num,
  output logic              is_nan,
  output logic              is_pinf,
  output logic              is_ninf
);

  fp16_fields_t cls;

  fp16_classify u_classify (
    .data   (in_data),
    .fields (cls)
  );

  state_t                   state_reg, state_next;
  logic                     sign_reg, sign_next;
  logic signed [UEXP_W-1:0] exp_reg, exp_next;
  logic [MANT_W-1:0]        mant_reg, mant_next;
  logic                     is_num_reg, is_num_next;
  logic                     is_nan_reg, is_nan_next;
  logic                     is_pinf_reg, is_pinf_next;
  logic                     is_ninf_reg, is_ninf_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      mant_reg    <= '0;
      is_num_reg  <= 1'b0;
      is_nan_reg  <= 1'b0;
      is_pinf_reg <= 1'b0;
      is_ninf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sign_reg    <= sign_next;
      exp_reg     <= exp_next;
      mant_reg    <= mant_next;
      is_num_reg  <= is_num_next;
      is_nan_reg  <= is_nan_next;
      is_pinf_reg <= is_pinf_next;
      is_ninf_reg <= is_ninf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sign_next    = sign_reg;
    exp_next     = exp_reg;
    mant_next    = mant_reg;
    is_num_next  = is_num_reg;
    is_nan_next  = is_nan_reg;
    is_pinf_next = is_pinf_reg;
    is_ninf_next = is_ninf_reg;

    if (!enable) begin
      state_next   = IDLE;
      sign_next    = 1'b0;
      exp_next     = '0;
      mant_next    = '0;
      is_num_next  = 1'b0;
      is_nan_next  = 1'b0;
      is_pinf_next = 1'b0;
      is_ninf_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_next    = cls.sign;
            exp_next     = cls.exp;
            mant_next    = cls.mant;
            is_num_next  = cls.is_num;
            is_nan_next  = cls.is_nan;
            is_pinf_next = cls.is_pinf;
            is_ninf_next = cls.is_ninf;
            state_next   = cls.need_norm ? NORM : HOLD;
          end
        end
        NORM: begin
          // Bit 9 becomes the leading one after this shift; bottoms out at -24.
          mant_next = {mant_reg[MANT_W-2:0], 1'b0};
          exp_next  = exp_reg - 7'sd1;
          if (mant_reg[MANT_W-2]) state_next = HOLD;
        end
        HOLD: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign n_valid  = (state_reg == HOLD);
  assign sign     = sign_reg;
  assign exp      = exp_reg;
  assign mant     = mant_reg;
  assign is_num   = is_num_reg;
  assign is_nan   = is_nan_reg;
  assign is_pinf  = is_pinf_reg;
  assign is_ninf  = is_ninf_reg;

endmodule
